download_sequencer: RTL and testbench

Sequences HPS ROM/RAM downloads into the Aznable system's single shared download write port. Sits between the ioctl interface of the emu wrapper and the system core: buffers one byte at a time, holds the host off with ioctl_wait while the core's memory port is busy, drops out-of-range bytes, and holds the system in reset for the whole download plus a fixed settle period afterwards.

---
 rtl/download_sequencer_pkg.sv | 13 +
 rtl/download_sequencer.sv | 132 +++++++++++++
 tb/tb_download_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/download_sequencer_pkg.sv
// Shared types and constants for the HPS download sequencer.
package download_sequencer_pkg;

  localparam int unsigned HOST_ADDR_W = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/download_sequencer.sv
// Funnels ioctl download bytes through a one-byte buffer into the core's shared
// write port, keeping the core in reset for the download plus a settle period.
module download_sequencer
  import download_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [HOST_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic [7:0]             ioctl_index,
  output logic                   ioctl_wait,
  input  logic                   mem_busy,
  output logic                   dn_wr,
  output logic [ADDR_W-1:0]      dn_addr,
  output logic [7:0]             dn_data,
  output logic [7:0]             dn_index,
  output logic                   sys_reset,
  output logic [ADDR_W:0]        dn_count,
  output logic [7:0]             dn_sum,
  output logic                   dn_err
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  state_t              state;
  state_t              state_nxt;
  logic                buf_full;
  logic [ADDR_W-1:0]   buf_addr;
  logic [7:0]          buf_data;
  logic [7:0]          buf_index;
  logic [HOLD_W-1:0]   hold_cnt;

  logic in_range;
  logic capture;
  logic drop;
  logic issue;
  logic start;

  // A strobe is only accepted into an empty buffer; anything else is lost.
  always_comb begin
    in_range = (ioctl_addr[HOST_ADDR_W-1:ADDR_W] == '0);
    capture  = (state == LOAD) && ioctl_wr && !buf_full && in_range;
    drop     = (state == LOAD) && ioctl_wr && (buf_full || !in_range);
    issue    = buf_full && !mem_busy;
    start    = (state == IDLE) && (state_nxt == LOAD);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ioctl_download) state_nxt = LOAD;
      LOAD:    if (!ioctl_download) state_nxt = DRAIN;
      DRAIN: begin
        if (ioctl_download)  state_nxt = LOAD;
        else if (!buf_full)  state_nxt = HOLD;
      end
      HOLD: begin
        if (ioctl_download)        state_nxt = LOAD;
        else if (hold_cnt == '0)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer, write port, settle counter and statistics.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      buf_full  <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      buf_index <= '0;
      hold_cnt  <= '0;
      dn_wr     <= 1'b0;
      dn_addr   <= '0;
      dn_data   <= '0;
      dn_index  <= '0;
      sys_reset <= 1'b1;
      dn_count  <= '0;
      dn_sum    <= '0;
      dn_err    <= 1'b0;
    end else begin
      sys_reset <= (state_nxt != IDLE);
      dn_wr     <= issue;

      if (capture) begin
        buf_full  <= 1'b1;
        buf_addr  <= ioctl_addr[ADDR_W-1:0];
        buf_data  <= ioctl_dout;
        buf_index <= ioctl_index;
      end else if (issue) begin
        buf_full <= 1'b0;
      end

      if (issue) begin
        dn_addr  <= buf_addr;
        dn_data  <= buf_data;
        dn_index <= buf_index;
      end

      if (state == DRAIN && state_nxt == HOLD)
        hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
      else if (state == HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - HOLD_W'(1);

      if (start) begin
        dn_count <= '0;
        dn_sum   <= '0;
        dn_err   <= 1'b0;
      end else begin
        if (issue) begin
          if (dn_count != '1) dn_count <= dn_count + CNT_W'(1);
          dn_sum <= dn_sum + buf_data;
        end
        if (drop) dn_err <= 1'b1;
      end
    end
  end

  assign ioctl_wait = buf_full;

endmodule

// File: tb/tb_download_sequencer.sv
// Scoreboard bench for download_sequencer: expected writes are queued at strobe time
// and checked (address, data, index, cycle) when dn_wr pulses.
module tb_download_sequencer;

  localparam int unsigned ADDR_W      = 17;
  localparam int unsigned HOLD_CYCLES = 16;

  logic              clk_sys        = 1'b0;
  logic              reset          = 1'b1;
  logic              ioctl_download = 1'b0;
  logic              ioctl_wr       = 1'b0;
  logic [24:0]       ioctl_addr     = '0;
  logic [7:0]        ioctl_dout     = '0;
  logic [7:0]        ioctl_index    = '0;
  logic              mem_busy       = 1'b0;
  logic              ioctl_wait;
  logic              dn_wr;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic [7:0]        dn_index;
  logic              sys_reset;
  logic [ADDR_W:0]   dn_count;
  logic [7:0]        dn_sum;
  logic              dn_err;

  download_sequencer #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .mem_busy(mem_busy),
    .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data), .dn_index(dn_index),
    .sys_reset(sys_reset), .dn_count(dn_count), .dn_sum(dn_sum), .dn_err(dn_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic [7:0]        index;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc         = 0;
  int   n_tests     = 0;
  int   n_fail      = 0;
  int   last_wr_cyc = -1;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Every write pulse must match the oldest queued expectation.
  always @(negedge clk_sys) begin
    if (dn_wr === 1'b1) begin
      last_wr_cyc = cyc;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h index=%h at cyc %0d, required no write",
                 dn_addr, dn_data, dn_index, cyc);
      end else begin
        e = sb.pop_front();
        if (dn_addr !== e.addr || dn_data !== e.data || dn_index !== e.index ||
            (e.cyc >= 0 && cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL write: got addr=%h data=%h index=%h cyc=%0d, required addr=%h data=%h index=%h cyc=%0d",
                   dn_addr, dn_data, dn_index, cyc, e.addr, e.data, e.index, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic push(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx, input int c);
    exp_t x;
    x.addr  = ADDR_W'(a);
    x.data  = d;
    x.index = idx;
    x.cyc   = c;
    sb.push_back(x);
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx);
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_index = idx;
    ioctl_wr    = 1'b1;
    tick(1);
    ioctl_wr    = 1'b0;
  endtask

  task automatic wait_release(output int fall);
    fall = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_sys);
      if (sys_reset === 1'b0) begin
        fall = cyc;
        break;
      end
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    @(negedge clk_sys);
    n_tests++;
    if ({ioctl_wait, dn_wr, dn_addr, dn_data, dn_index, sys_reset, dn_count, dn_sum, dn_err} !==
        {1'b0, 1'b0, 17'h0, 8'h0, 8'h0, 1'b1, 18'h0, 8'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got wait=%b wr=%b addr=%h data=%h idx=%h sysrst=%b cnt=%h sum=%h err=%b, required 0 0 0 0 0 1 0 0 0",
               ioctl_wait, dn_wr, dn_addr, dn_data, dn_index, sys_reset, dn_count, dn_sum, dn_err);
    end
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    tick(1);
    @(negedge clk_sys);
    n_tests++;
    if (sys_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_release: got sys_reset=%b, required 0", sys_reset);
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_basic;
    logic [7:0] d;
    int fall;
    ioctl_download = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'h11 * (i + 1));
      push(25'(i), d, 8'h00, cyc + 2);
      strobe(25'(i), d, 8'h00);
      if (i < 3) tick(1);
    end
    ioctl_download = 1'b0;
    wait_release(fall);
    n_tests++;
    if (fall - last_wr_cyc != HOLD_CYCLES + 1) begin
      n_fail++;
      $display("FAIL basic_release: got %0d cycles after last write (fall=%0d), required %0d",
               fall - last_wr_cyc, fall, HOLD_CYCLES + 1);
    end
    n_tests++;
    if ({dn_count, dn_sum, dn_err} !== {18'd4, 8'hAA, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_stats: got cnt=%0d sum=%h err=%b, required 4 aa 0", dn_count, dn_sum, dn_err);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL basic_pending: got %0d writes outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_busy;
    int waits;
    waits = 0;
    ioctl_download = 1'b1;
    tick(1);
    push(25'h10, 8'hA5, 8'h03, cyc + 7);
    strobe(25'h10, 8'hA5, 8'h03);
    for (int k = 1; k <= 7; k++) begin
      mem_busy = (k <= 5);
      @(negedge clk_sys);
      if (ioctl_wait === 1'b1) waits++;
      @(posedge clk_sys);
      #1;
    end
    n_tests++;
    if (waits != 6) begin
      n_fail++;
      $display("FAIL busy_wait_len: got %0d wait cycles, required 6", waits);
    end
    n_tests++;
    if ({dn_count, dn_sum} !== {18'd1, 8'hA5}) begin
      n_fail++;
      $display("FAIL busy_stats: got cnt=%0d sum=%h, required 1 a5", dn_count, dn_sum);
    end
  endtask

  task automatic test_range;
    int fall;
    strobe(25'h20000, 8'h66, 8'h00);
    tick(2);
    n_tests++;
    if ({dn_err, dn_count} !== {1'b1, 18'd1}) begin
      n_fail++;
      $display("FAIL range_drop: got err=%b cnt=%0d, required 1 1", dn_err, dn_count);
    end
    push(25'h1FFFF, 8'h5A, 8'h01, cyc + 2);
    strobe(25'h1FFFF, 8'h5A, 8'h01);
    tick(2);
    n_tests++;
    if ({dn_err, dn_count, dn_sum} !== {1'b1, 18'd2, 8'hFF}) begin
      n_fail++;
      $display("FAIL range_top: got err=%b cnt=%0d sum=%h, required 1 2 ff", dn_err, dn_count, dn_sum);
    end
    ioctl_download = 1'b0;
    wait_release(fall);
    n_tests++;
    if (fall < 0) begin
      n_fail++;
      $display("FAIL range_release: got sys_reset stuck high, required release");
    end
  endtask

  task automatic test_overrun;
    ioctl_download = 1'b1;
    tick(1);
    @(negedge clk_sys);
    n_tests++;
    if ({dn_count, dn_sum, dn_err} !== {18'd0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL stats_clear: got cnt=%0d sum=%h err=%b, required 0 00 0", dn_count, dn_sum, dn_err);
    end
    @(posedge clk_sys);
    #1;
    mem_busy = 1'b1;
    push(25'h5, 8'h77, 8'h02, -1);
    strobe(25'h5, 8'h77, 8'h02);
    strobe(25'h6, 8'h55, 8'h02);
    mem_busy = 1'b0;
    tick(3);
    n_tests++;
    if ({dn_err, dn_count, dn_sum, dn_data, dn_addr} !== {1'b1, 18'd1, 8'h77, 8'h77, 17'h5}) begin
      n_fail++;
      $display("FAIL overrun: got err=%b cnt=%0d sum=%h data=%h addr=%h, required 1 1 77 77 00005",
               dn_err, dn_count, dn_sum, dn_data, dn_addr);
    end
  endtask

  task automatic test_rehold;
    int lows;
    lows = 0;
    ioctl_download = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_sys);
      if (sys_reset !== 1'b1) lows++;
      @(posedge clk_sys);
      #1;
    end
    ioctl_download = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_sys);
      if (sys_reset !== 1'b1) lows++;
      @(posedge clk_sys);
      #1;
    end
    push(25'h7, 8'h99, 8'h04, cyc + 2);
    strobe(25'h7, 8'h99, 8'h04);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_sys);
      if (sys_reset !== 1'b1) lows++;
      @(posedge clk_sys);
      #1;
    end
    n_tests++;
    if (lows != 0) begin
      n_fail++;
      $display("FAIL rehold_sysrst: got %0d low cycles, required 0", lows);
    end
    n_tests++;
    if ({dn_count, dn_sum, dn_err} !== {18'd2, 8'h10, 1'b1}) begin
      n_fail++;
      $display("FAIL rehold_stats: got cnt=%0d sum=%h err=%b, required 2 10 1", dn_count, dn_sum, dn_err);
    end
  endtask

  task automatic test_reset_mid;
    mem_busy = 1'b1;
    strobe(25'h8, 8'hEE, 8'h05);
    reset = 1'b1;
    tick(2);
    @(negedge clk_sys);
    n_tests++;
    if ({ioctl_wait, dn_wr, dn_addr, dn_data, dn_index, sys_reset, dn_count, dn_sum, dn_err} !==
        {1'b0, 1'b0, 17'h0, 8'h0, 8'h0, 1'b1, 18'h0, 8'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_values: got wait=%b wr=%b addr=%h data=%h idx=%h sysrst=%b cnt=%h sum=%h err=%b, required 0 0 0 0 0 1 0 0 0",
               ioctl_wait, dn_wr, dn_addr, dn_data, dn_index, sys_reset, dn_count, dn_sum, dn_err);
    end
    @(posedge clk_sys);
    #1;
    reset          = 1'b0;
    mem_busy       = 1'b0;
    ioctl_download = 1'b0;
    tick(4);
    @(negedge clk_sys);
    n_tests++;
    if ({sys_reset, ioctl_wait, dn_count} !== {1'b0, 1'b0, 18'd0}) begin
      n_fail++;
      $display("FAIL midreset_idle: got sysrst=%b wait=%b cnt=%0d, required 0 0 0", sys_reset, ioctl_wait, dn_count);
    end
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    tick(1);
    test_reset();
    test_basic();
    test_busy();
    test_range();
    test_overrun();
    test_rehold();
    test_reset_mid();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL final_pending: got %0d writes outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
